div_issue_wb: RTL and testbench

- Sequencer wrapped around the 16-bit iterative divider FSM. It sits between instruction decode and the divider, and between the divider and register-file writeback.
- Upstream: accepts divide/remainder requests over valid/ready, launches the divider, and waits for completion.
- Downstream: selects the quotient or remainder, then queues the result with its destination tag in a small FIFO for the writeback port.
- Divide-by-zero is resolved locally; the divider is not launched.

---
 rtl/div_issue_wb_if.sv | 45 ++++
 rtl/div_issue_wb.sv | 250 +++++++++++++++++++++++++
 tb/tb_div_issue_wb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_wb_if.sv
// Bundle for the divide sequencer: request channel, divider handshake and
// writeback channel. The slave modport is the sequencer's own view.
interface div_issue_wb_if #(
  parameter int N     = 16,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     req_dividend;
  logic [N-1:0]     req_divisor;
  logic             req_op;
  logic [TAG_W-1:0] req_tag;

  logic             div_go;
  logic [N-1:0]     div_dividend;
  logic [N-1:0]     div_divisor;
  logic             div_done;
  logic [N-1:0]     div_quotient;
  logic [N-1:0]     div_remainder;

  logic             wb_valid;
  logic             wb_ready;
  logic [N-1:0]     wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_dz;
  logic             wb_tmo;

  modport master (
    output req_valid, req_dividend, req_divisor, req_op, req_tag,
    input  req_ready,
    input  div_go, div_dividend, div_divisor,
    output div_done, div_quotient, div_remainder,
    input  wb_valid, wb_data, wb_tag, wb_dz, wb_tmo,
    output wb_ready
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_op, req_tag,
    output req_ready,
    output div_go, div_dividend, div_divisor,
    input  div_done, div_quotient, div_remainder,
    output wb_valid, wb_data, wb_tag, wb_dz, wb_tmo,
    input  wb_ready
  );
endinterface

// File: rtl/div_issue_wb.sv
// Issue/writeback sequencer around an iterative divider with a small result FIFO.
// Optional divider watchdog enabled by defining DIV_TIMEOUT_EN.
module div_issue_wb #(
  parameter int N          = 16,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TMO_CYCLES = 140000
) (
  input  logic           clk,
  input  logic           reset,
  div_issue_wb_if.slave  bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    PUSH   = 2'd3
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef DIV_TIMEOUT_EN
  localparam int ENT_W = N + TAG_W + 2;
  localparam int TCW   = $clog2(TMO_CYCLES);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYCLES - 1);
`else
  localparam int ENT_W = N + TAG_W + 1;
`endif

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TMO_CYCLES < 2)) begin : g_cfg_check
    $error("div_issue_wb: FIFO_DEPTH must be a power of 2 >= 2 and TMO_CYCLES >= 2");
  end

  state_t           state_q, state_d;
  logic [N-1:0]     dividend_q, dividend_d;
  logic [N-1:0]     divisor_q, divisor_d;
  logic [N-1:0]     div_dividend_q, div_dividend_d;
  logic [N-1:0]     div_divisor_q, div_divisor_d;
  logic [N-1:0]     result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             op_q, op_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             div_go_q, div_go_d;
  logic             req_ready_q, req_ready_d;
`ifdef DIV_TIMEOUT_EN
  logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;
`endif

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept_s;
  logic             completion_s;
  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] entry_s;
  logic [ENT_W-1:0] head_s;

  assign accept_s     = bus.req_valid & req_ready_q;
  // A done level left high by the previous operation is not a completion.
  assign completion_s = bus.div_done & ~done_q;
  assign pop_s        = (count_q != {CNT_W{1'b0}}) & bus.wb_ready;
`ifdef DIV_TIMEOUT_EN
  assign entry_s      = {result_q, tag_q, dz_q, tmo_q};
`else
  assign entry_s      = {result_q, tag_q, dz_q};
`endif

  // Next-state logic for the sequencer FSM and the result FIFO
  always_comb begin
    state_d        = state_q;
    dividend_d     = dividend_q;
    divisor_d      = divisor_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    result_d       = result_q;
    tag_d          = tag_q;
    op_d           = op_q;
    dz_d           = dz_q;
    done_d         = done_q;
    div_go_d       = 1'b0;
    push_s         = 1'b0;
`ifdef DIV_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    tmo_d          = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          dividend_d = bus.req_dividend;
          divisor_d  = bus.req_divisor;
          op_d       = bus.req_op;
          tag_d      = bus.req_tag;
`ifdef DIV_TIMEOUT_EN
          tmo_d      = 1'b0;
`endif
          if (bus.req_divisor == {N{1'b0}}) begin
            dz_d     = 1'b1;
            result_d = bus.req_op ? bus.req_dividend : {N{1'b1}};
            state_d  = PUSH;
          end else begin
            dz_d           = 1'b0;
            div_dividend_d = bus.req_dividend;
            div_divisor_d  = bus.req_divisor;
            div_go_d       = 1'b1;
            state_d        = LAUNCH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        done_d  = 1'b0;
`ifdef DIV_TIMEOUT_EN
        tmo_cnt_d = {TCW{1'b0}};
`endif
        state_d = WAIT;
      end
      WAIT: begin
        done_d = bus.div_done;
        if (completion_s) begin
          result_d = op_q ? bus.div_remainder : bus.div_quotient;
          state_d  = PUSH;
`ifdef DIV_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Give up on the divider and pulse go again to re-initialise it.
          result_d = {N{1'b0}};
          tmo_d    = 1'b1;
          div_go_d = 1'b1;
          state_d  = PUSH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1'b1);
          state_d   = WAIT;
`else
        end else begin
          state_d = WAIT;
`endif
        end
      end
      PUSH: begin
        push_s  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = entry_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase

    // Only offer a new request when its FIFO slot is already guaranteed.
    req_ready_d = (state_d == IDLE) && (count_d < DEPTH_C);
  end

  // State, operand, result and FIFO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      dividend_q     <= {N{1'b0}};
      divisor_q      <= {N{1'b0}};
      div_dividend_q <= {N{1'b0}};
      div_divisor_q  <= {N{1'b0}};
      result_q       <= {N{1'b0}};
      tag_q          <= {TAG_W{1'b0}};
      op_q           <= 1'b0;
      dz_q           <= 1'b0;
      done_q         <= 1'b0;
      div_go_q       <= 1'b0;
      req_ready_q    <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      tmo_cnt_q      <= {TCW{1'b0}};
      tmo_q          <= 1'b0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      dividend_q     <= dividend_d;
      divisor_q      <= divisor_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      result_q       <= result_d;
      tag_q          <= tag_d;
      op_q           <= op_d;
      dz_q           <= dz_d;
      done_q         <= done_d;
      div_go_q       <= div_go_d;
      req_ready_q    <= req_ready_d;
`ifdef DIV_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      tmo_q          <= tmo_d;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  assign head_s           = mem_q[rd_ptr_q];
  assign bus.req_ready    = req_ready_q;
  assign bus.div_go       = div_go_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;
  assign bus.wb_valid     = (count_q != {CNT_W{1'b0}});
  assign bus.wb_data      = head_s[ENT_W-1 -: N];
  assign bus.wb_tag       = head_s[ENT_W-N-1 -: TAG_W];
`ifdef DIV_TIMEOUT_EN
  assign bus.wb_dz        = head_s[1];
  assign bus.wb_tmo       = head_s[0];
`else
  assign bus.wb_dz        = head_s[0];
  assign bus.wb_tmo       = 1'b0;
`endif
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_div_issue_wb.sv
// Directed bench for div_issue_wb with a behavioural multi-cycle divider model.
module tb_div_issue_wb;

`ifdef DIV_TIMEOUT_EN
  localparam int TMO = 32;
`else
  localparam int TMO = 140000;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   vectors = 0;
  int   errors  = 0;

  div_issue_wb_if #(.N(16), .TAG_W(4)) bus_if ();

  div_issue_wb #(.N(16), .TAG_W(4), .FIFO_DEPTH(2), .TMO_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Divider model: restarts on go, raises done 6 cycles later, holds it until next go.
  logic        m_done = 1'b0;
  logic [15:0] m_q    = 16'd0;
  logic [15:0] m_r    = 16'd0;
  int          m_cnt  = 0;
  int          go_count = 0;
  bit          div_stall = 1'b0;

  assign bus_if.div_done      = m_done;
  assign bus_if.div_quotient  = m_q;
  assign bus_if.div_remainder = m_r;

  always @(posedge clk) begin
    if (bus_if.div_go === 1'b1) begin
      go_count <= go_count + 1;
      m_done   <= 1'b0;
      m_cnt    <= 6;
      if (bus_if.div_divisor != 16'd0) begin
        m_q <= bus_if.div_dividend / bus_if.div_divisor;
        m_r <= bus_if.div_dividend % bus_if.div_divisor;
      end else begin
        m_q <= 16'hFFFF;
        m_r <= bus_if.div_dividend;
      end
    end else if (!div_stall && m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic op, input logic [3:0] t);
    int n = 0;
    bus_if.req_dividend = a;
    bus_if.req_divisor  = b;
    bus_if.req_op       = op;
    bus_if.req_tag      = t;
    bus_if.req_valid    = 1'b1;
    while (bus_if.req_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(bus_if.req_ready), 32'd1);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_wb(input string tag, input logic [15:0] data, input logic [3:0] t,
                         input logic dz, input logic tmo);
    int n = 0;
    while (bus_if.wb_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus_if.wb_valid), 32'd1);
    check({tag, "_data"},  32'(bus_if.wb_data),  32'(data));
    check({tag, "_tag"},   32'(bus_if.wb_tag),   32'(t));
    check({tag, "_dz"},    32'(bus_if.wb_dz),    32'(dz));
    check({tag, "_tmo"},   32'(bus_if.wb_tmo),   32'(tmo));
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    int g0;
    int n;
    reset               = 1'b1;
    bus_if.req_valid    = 1'b0;
    bus_if.req_dividend = 16'd0;
    bus_if.req_divisor  = 16'd0;
    bus_if.req_op       = 1'b0;
    bus_if.req_tag      = 4'd0;
    bus_if.wb_ready     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    check("rst_wb_valid",  32'(bus_if.wb_valid),  32'd0);
    check("rst_div_go",    32'(bus_if.div_go),    32'd0);
    check("rst_busy",      32'(busy),             32'd0);
    check("rst_wb_data",   32'(bus_if.wb_data),   32'd0);
    check("rst_wb_tmo",    32'(bus_if.wb_tmo),    32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_if.req_ready), 32'd1);

    // 100/7 quotient with completion-to-writeback latency
    issue(16'd100, 16'd7, 1'b0, 4'd3);
    check("launch_dividend", 32'(bus_if.div_dividend), 32'd100);
    check("launch_divisor",  32'(bus_if.div_divisor),  32'd7);
    n = 0;
    while (m_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(m_done), 32'd1);
    check("lat_c0", 32'(bus_if.wb_valid), 32'd0);
    @(negedge clk);
    check("lat_c1", 32'(bus_if.wb_valid), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(bus_if.wb_valid), 32'd1);
    wait_wb("q100_7", 16'd14, 4'd3, 1'b0, 1'b0);

    // Remainder with stale done still high from the previous operation
    issue(16'd100, 16'd7, 1'b1, 4'd3);
    wait_wb("r100_7", 16'd2, 4'd3, 1'b0, 1'b0);
    issue(16'd5, 16'd9, 1'b0, 4'd1);
    wait_wb("q5_9", 16'd0, 4'd1, 1'b0, 1'b0);
    issue(16'd5, 16'd9, 1'b1, 4'd2);
    wait_wb("r5_9", 16'd5, 4'd2, 1'b0, 1'b0);

    // Divide-by-zero: no launch, writeback two cycles after accept
    g0 = go_count;
    check("dz_ready", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_dividend = 16'd1234;
    bus_if.req_divisor  = 16'd0;
    bus_if.req_op       = 1'b0;
    bus_if.req_tag      = 4'd9;
    bus_if.req_valid    = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("dz_c1_valid", 32'(bus_if.wb_valid), 32'd0);
    check("dz_c1_busy",  32'(busy),            32'd1);
    check("dz_c1_go",    32'(bus_if.div_go),   32'd0);
    @(negedge clk);
    check("dz_c2_valid", 32'(bus_if.wb_valid), 32'd1);
    wait_wb("dz_q", 16'hFFFF, 4'd9, 1'b1, 1'b0);
    issue(16'd1234, 16'd0, 1'b1, 4'd10);
    wait_wb("dz_r", 16'h04D2, 4'd10, 1'b1, 1'b0);
    check("dz_no_go", 32'(go_count), 32'(g0));

    // Backpressure: two results fill the FIFO, the third waits for a pop
    issue(16'd20, 16'd3, 1'b0, 4'd1);
    issue(16'd20, 16'd3, 1'b1, 4'd2);
    wait_idle();
    check("bp_full_ready", 32'(bus_if.req_ready), 32'd0);
    bus_if.req_dividend = 16'd50;
    bus_if.req_divisor  = 16'd5;
    bus_if.req_op       = 1'b0;
    bus_if.req_tag      = 4'd5;
    bus_if.req_valid    = 1'b1;
    @(negedge clk);
    check("bp_hold_busy", 32'(busy),           32'd0);
    check("bp_head_data", 32'(bus_if.wb_data), 32'd6);
    check("bp_head_tag",  32'(bus_if.wb_tag),  32'd1);
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    check("bp_2nd_data",  32'(bus_if.wb_data),   32'd2);
    check("bp_2nd_tag",   32'(bus_if.wb_tag),    32'd2);
    check("bp_ready_up",  32'(bus_if.req_ready), 32'd1);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.wb_ready  = 1'b0;
    check("bp_empty",     32'(bus_if.wb_valid), 32'd0);
    check("bp_3rd_busy",  32'(busy),            32'd1);
    wait_wb("bp_3rd", 16'd10, 4'd5, 1'b0, 1'b0);

    // Reset while waiting on the divider
    div_stall = 1'b1;
    issue(16'd65535, 16'd1, 1'b0, 4'd7);
    repeat (3) @(negedge clk);
    check("rw_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rw_busy0",     32'(busy),                32'd0);
    check("rw_ready0",    32'(bus_if.req_ready),    32'd0);
    check("rw_valid0",    32'(bus_if.wb_valid),     32'd0);
    check("rw_go0",       32'(bus_if.div_go),       32'd0);
    check("rw_dividend0", 32'(bus_if.div_dividend), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    div_stall = 1'b0;
    @(negedge clk);
    check("rw_ready1", 32'(bus_if.req_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("rw_no_push", 32'(bus_if.wb_valid), 32'd0);
    issue(16'd9, 16'd4, 1'b1, 4'd8);
    wait_wb("post_rw", 16'd1, 4'd8, 1'b0, 1'b0);

`ifdef DIV_TIMEOUT_EN
    // Watchdog: divider never completes
    div_stall = 1'b1;
    g0 = go_count;
    issue(16'd300, 16'd3, 1'b0, 4'd6);
    wait_wb("tmo", 16'd0, 4'd6, 1'b0, 1'b1);
    check("tmo_go_twice", 32'(go_count), 32'(g0 + 2));
    check("tmo_idle",     32'(busy),     32'd0);
    div_stall = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
